// File: rtl/ahb_aes_pkg.sv
// Shared AHB/AES bus types, addresses and master state encoding.
// Used by the master, the slave side and the bench.
package ahb_aes_pkg;

   typedef enum logic [1:0] {
      HT_IDLE   = 2'b00,
      HT_NONSEQ = 2'b10
   } htrans_t;

   typedef enum logic [1:0] {
      OP_WKEY  = 2'b00,
      OP_WDATA = 2'b01,
      OP_RDATA = 2'b10,
      OP_ILL   = 2'b11
   } op_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_DATA,
      S_ERRWAIT,
      S_RESP
   } mst_state_t;

   localparam logic [15:0] KEY_ADDR  = 16'h0000;
   localparam logic [15:0] DATA_ADDR = 16'h0020;

endpackage

// File: rtl/ahb_wait_timer.sv
// Saturating 8-bit count of consecutive wait cycles; expired flags the
// cycle that would be the LIMIT-th one.
module ahb_wait_timer #(
   parameter int unsigned LIMIT = 16
) (
   input  logic clk,
   input  logic clr,
   input  logic en,
   output logic expired
);

   logic [7:0] cnt;

   always_ff @(posedge clk) begin
      if (clr) begin
         cnt <= '0;
      end else if (en && cnt != 8'hFF) begin
         cnt <= cnt + 8'd1;
      end
   end

   assign expired = en && (({1'b0, cnt} + 9'd1) >= 9'(LIMIT));

endmodule

// File: rtl/ahb_aes_master.sv
// Single-transfer AHB master for the AES slave port.
// Define AHB_MASTER_TIMEOUT_EN to abort stalled transfers after TIMEOUT_CYCLES.
module ahb_aes_master
   import ahb_aes_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic [1:0]   cmd_op,
   input  logic [127:0] cmd_wdata,
   output logic         rsp_valid,
   output logic         rsp_err,
   output logic [127:0] rsp_rdata,
   output logic [15:0]  HADDR,
   output logic         HWRITE,
   output logic [1:0]   HTRANS,
   output logic [127:0] HWDATA,
   input  logic [127:0] HRDATA,
   input  logic         HREADY,
   input  logic         HRESP
);

   mst_state_t   state, state_nxt;
   op_t          op_q;
   logic [127:0] wdata_q;
   logic         err_q, err_nxt;
   logic         ld_rdata;
   logic [127:0] rdata_nxt;
   logic         tmo_en, tmo_clr, tmo_exp;
   logic         is_wr;
   logic [15:0]  addr;

   assign is_wr = (op_q != OP_RDATA);
   assign addr  = (op_q == OP_WKEY) ? KEY_ADDR : DATA_ADDR;

   // Wait counting lives outside the FSM block to keep the path acyclic.
   assign tmo_en  = !HREADY && (state == S_ADDR || state == S_DATA ||
                                state == S_ERRWAIT);
   assign tmo_clr = rst || !tmo_en || (state_nxt != state);

`ifdef AHB_MASTER_TIMEOUT_EN
   ahb_wait_timer #(
      .LIMIT(TIMEOUT_CYCLES)
   ) u_timer (
      .clk    (clk),
      .clr    (tmo_clr),
      .en     (tmo_en),
      .expired(tmo_exp)
   );
`else
   logic [7:0] unused_timeout;
   logic       unused_tmo;
   assign unused_timeout = 8'(TIMEOUT_CYCLES);
   assign unused_tmo     = tmo_clr;
   assign tmo_exp        = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         op_q      <= OP_WKEY;
         wdata_q   <= '0;
         err_q     <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         state <= state_nxt;
         err_q <= err_nxt;
         if (cmd_valid && cmd_ready) begin
            op_q    <= op_t'(cmd_op);
            wdata_q <= cmd_wdata;
         end
         if (ld_rdata) begin
            rsp_rdata <= rdata_nxt;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      err_nxt   = err_q;
      ld_rdata  = 1'b0;
      rdata_nxt = '0;
      cmd_ready = 1'b0;
      rsp_valid = 1'b0;
      rsp_err   = 1'b0;
      HTRANS    = HT_IDLE;
      HADDR     = '0;
      HWRITE    = 1'b0;
      HWDATA    = '0;
      unique case (state)
         S_IDLE: begin
            cmd_ready = !rst;
            if (cmd_valid && !rst) begin
               if (op_t'(cmd_op) == OP_ILL) begin
                  state_nxt = S_RESP;
                  err_nxt   = 1'b1;
                  ld_rdata  = 1'b1;
               end else begin
                  state_nxt = S_ADDR;
                  err_nxt   = 1'b0;
               end
            end
         end
         S_ADDR: begin
            HTRANS = HT_NONSEQ;
            HADDR  = addr;
            HWRITE = is_wr;
            if (HREADY) begin
               state_nxt = S_DATA;
            end else if (tmo_exp) begin
               state_nxt = S_RESP;
               err_nxt   = 1'b1;
               ld_rdata  = 1'b1;
            end
         end
         S_DATA: begin
            HADDR  = addr;
            HWRITE = is_wr;
            HWDATA = is_wr ? wdata_q : '0;
            if (HREADY) begin
               state_nxt = S_RESP;
               err_nxt   = HRESP;
               ld_rdata  = 1'b1;
               rdata_nxt = (!HRESP && !is_wr) ? HRDATA : '0;
            end else if (HRESP) begin
               state_nxt = S_ERRWAIT;
            end else if (tmo_exp) begin
               state_nxt = S_RESP;
               err_nxt   = 1'b1;
               ld_rdata  = 1'b1;
            end
         end
         S_ERRWAIT: begin
            HADDR  = addr;
            HWRITE = is_wr;
            if (HREADY || tmo_exp) begin
               state_nxt = S_RESP;
               err_nxt   = 1'b1;
               ld_rdata  = 1'b1;
            end
         end
         S_RESP: begin
            rsp_valid = 1'b1;
            rsp_err   = err_q;
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_ahb_aes_master.sv
// Directed bench for ahb_aes_master: vector table plus wait/error/reset cases.
// Expects AHB_MASTER_TIMEOUT_EN to match the RTL build.
module tb_ahb_aes_master;

   logic         clk = 1'b0;
   logic         rst;
   logic         cmd_valid;
   logic         cmd_ready;
   logic [1:0]   cmd_op;
   logic [127:0] cmd_wdata;
   logic         rsp_valid;
   logic         rsp_err;
   logic [127:0] rsp_rdata;
   logic [15:0]  HADDR;
   logic         HWRITE;
   logic [1:0]   HTRANS;
   logic [127:0] HWDATA;
   logic [127:0] HRDATA;
   logic         HREADY;
   logic         HRESP;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   ahb_aes_master #(
      .TIMEOUT_CYCLES(4)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_op   (cmd_op),
      .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid),
      .rsp_err  (rsp_err),
      .rsp_rdata(rsp_rdata),
      .HADDR    (HADDR),
      .HWRITE   (HWRITE),
      .HTRANS   (HTRANS),
      .HWDATA   (HWDATA),
      .HRDATA   (HRDATA),
      .HREADY   (HREADY),
      .HRESP    (HRESP)
   );

   typedef struct {
      logic [1:0]   op;
      logic [127:0] wdata;
      logic [127:0] hrdata;
      logic [15:0]  addr;
      logic         hwrite;
      logic [127:0] hwdata;
      logic         err;
      logic [127:0] rdata;
   } vec_t;

   vec_t vecs[6];

   localparam logic [127:0] KEY = 128'h000102030405060708090A0B0C0D0E0F;
   localparam logic [127:0] WD  = 128'hAAAA5555AAAA5555AAAA5555AAAA5555;
   localparam logic [127:0] RD1 = 128'hCAFEF00D_12345678_9ABCDEF0_0F1E2D3C;
   localparam logic [127:0] RD2 = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
   localparam logic [127:0] RD3 = 128'h0123456789ABCDEF0011223344556677;

   task automatic chk(input string nm, input logic [127:0] act,
                      input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_ready"}, cmd_ready, 0);
      chk({tag, "_rspv"}, rsp_valid, 0);
      chk({tag, "_rspe"}, rsp_err, 0);
      chk({tag, "_rdata"}, rsp_rdata, 0);
      chk({tag, "_haddr"}, HADDR, 0);
      chk({tag, "_hwrite"}, HWRITE, 0);
      chk({tag, "_htrans"}, HTRANS, 0);
      chk({tag, "_hwdata"}, HWDATA, 0);
   endtask

   task automatic run_vec(input vec_t v);
      chk("pre_ready", cmd_ready, 1);
      cmd_valid = 1'b1;
      cmd_op    = v.op;
      cmd_wdata = v.wdata;
      HRDATA    = v.hrdata;
      @(negedge clk);
      cmd_valid = 1'b0;
      if (v.op != 2'b11) begin
         chk("addr_htrans", HTRANS, 2'b10);
         chk("addr_haddr", HADDR, v.addr);
         chk("addr_hwrite", HWRITE, v.hwrite);
         chk("addr_ready", cmd_ready, 0);
         @(negedge clk);
         chk("data_htrans", HTRANS, 2'b00);
         chk("data_haddr", HADDR, v.addr);
         chk("data_hwrite", HWRITE, v.hwrite);
         chk("data_hwdata", HWDATA, v.hwdata);
         @(negedge clk);
      end
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_err", rsp_err, v.err);
      chk("rsp_rdata", rsp_rdata, v.rdata);
      chk("rsp_htrans", HTRANS, 2'b00);
      @(negedge clk);
      chk("post_valid", rsp_valid, 0);
      chk("post_rdata", rsp_rdata, v.rdata);
      chk("post_ready", cmd_ready, 1);
   endtask

   task automatic start_cmd(input logic [1:0] op, input logic [127:0] wd);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_wdata = wd;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   initial begin
      int nrsp;
      vecs[0] = '{2'b00, KEY, RD3, 16'h0000, 1'b1, KEY, 1'b0, 128'h0};
      vecs[1] = '{2'b01, WD,  RD3, 16'h0020, 1'b1, WD,  1'b0, 128'h0};
      vecs[2] = '{2'b10, WD,  RD1, 16'h0020, 1'b0, 128'h0, 1'b0, RD1};
      vecs[3] = '{2'b11, KEY, RD3, 16'h0000, 1'b0, 128'h0, 1'b1, 128'h0};
      vecs[4] = '{2'b10, KEY, RD3, 16'h0020, 1'b0, 128'h0, 1'b0, RD3};
      vecs[5] = '{2'b00, WD,  RD1, 16'h0000, 1'b1, WD,  1'b0, 128'h0};

      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = 2'b00;
      cmd_wdata = '0;
      HRDATA    = '0;
      HREADY    = 1'b1;
      HRESP     = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;
      @(negedge clk);
      chk("reset_release_ready", cmd_ready, 1);

      for (int i = 0; i < 6; i++) begin
         run_vec(vecs[i]);
      end

      // Read with three HREADY-low data-phase cycles.
      HRDATA = RD3;
      start_cmd(2'b10, '0);
      chk("ws_addr_htrans", HTRANS, 2'b10);
      @(negedge clk);
      HREADY = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk("ws_haddr", HADDR, 16'h0020);
         chk("ws_rspv", rsp_valid, 0);
         @(negedge clk);
      end
      HREADY = 1'b1;
      HRDATA = RD2;
      chk("ws_haddr_last", HADDR, 16'h0020);
      @(negedge clk);
      chk("ws_rspv_t6", rsp_valid, 1);
      chk("ws_rspe", rsp_err, 0);
      chk("ws_rdata", rsp_rdata, RD2);
      @(negedge clk);

      // Two-cycle error response on a data write.
      start_cmd(2'b01, WD);
      @(negedge clk);
      HRESP  = 1'b1;
      HREADY = 1'b0;
      @(negedge clk);
      chk("err_wait_htrans", HTRANS, 2'b00);
      chk("err_wait_rspv", rsp_valid, 0);
      HREADY = 1'b1;
      @(negedge clk);
      HRESP = 1'b0;
      chk("err_rspv", rsp_valid, 1);
      chk("err_rspe", rsp_err, 1);
      chk("err_rdata", rsp_rdata, 0);
      chk("err_htrans", HTRANS, 2'b00);
      @(negedge clk);

      // Collapsed error response on a read.
      HRDATA = RD1;
      start_cmd(2'b10, '0);
      @(negedge clk);
      HRESP = 1'b1;
      @(negedge clk);
      HRESP = 1'b0;
      chk("cerr_rspv", rsp_valid, 1);
      chk("cerr_rspe", rsp_err, 1);
      chk("cerr_rdata", rsp_rdata, 0);
      @(negedge clk);

      // cmd_valid held with an illegal op while busy must be ignored.
      HRDATA = RD1;
      start_cmd(2'b10, '0);
      cmd_valid = 1'b1;
      cmd_op    = 2'b11;
      chk("busy_ready_a", cmd_ready, 0);
      @(negedge clk);
      chk("busy_ready_d", cmd_ready, 0);
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("busy_rspv", rsp_valid, 1);
      chk("busy_rspe", rsp_err, 0);
      chk("busy_rdata", rsp_rdata, RD1);
      @(negedge clk);
      chk("busy_post_rspv", rsp_valid, 0);
      @(negedge clk);
      chk("busy_post2_rspv", rsp_valid, 0);
      chk("busy_post2_ready", cmd_ready, 1);

      // Reset during DATA drops the command.
      start_cmd(2'b00, KEY);
      @(negedge clk);
      chk("rstd_hwdata", HWDATA, KEY);
      rst    = 1'b1;
      HREADY = 1'b0;
      @(negedge clk);
      check_reset_outputs("rstd");
      rst    = 1'b0;
      HREADY = 1'b1;
      @(negedge clk);
      chk("rstd_after_rspv", rsp_valid, 0);
      run_vec(vecs[4]);

      // Data phase stuck with HREADY low.
      start_cmd(2'b10, '0);
      @(negedge clk);
      HREADY = 1'b0;
`ifdef AHB_MASTER_TIMEOUT_EN
      for (int k = 0; k < 4; k++) begin
         chk("tmo_wait_rspv", rsp_valid, 0);
         @(negedge clk);
      end
      chk("tmo_rspv", rsp_valid, 1);
      chk("tmo_rspe", rsp_err, 1);
      chk("tmo_rdata", rsp_rdata, 0);
      chk("tmo_htrans", HTRANS, 2'b00);
      @(negedge clk);
      HREADY = 1'b1;
      chk("tmo_post_ready", cmd_ready, 1);
`else
      nrsp = 0;
      for (int k = 0; k < 100; k++) begin
         if (rsp_valid) nrsp++;
         @(negedge clk);
      end
      chk("stuck_no_rsp", nrsp, 0);
      chk("stuck_haddr", HADDR, 16'h0020);
      rst = 1'b1;
      @(negedge clk);
      check_reset_outputs("stuck_rst");
      rst    = 1'b0;
      HREADY = 1'b1;
      @(negedge clk);
`endif
      run_vec(vecs[0]);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
